mux_select_arbiter: RTL

- Round-robin arbiter that sits directly upstream of the 4:1 mux and drives its s1/s0 select lines.
- Four sources raise requests. The arbiter grants one source at a time for a bounded burst.
- It presents the winning index as the mux select pair, plus a one-hot grant back to the sources.
- The mux data path itself is unchanged; this block only owns the select sequencing.

---
 rtl/mux_select_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter
// Round-robin arbiter that owns the s1/s0 select pair of a downstream 4:1 mux.
// One source holds the mux for a burst of up to BURST_LEN cycles. It then
// hands over to the next pending requester with no idle cycle in between.
module mux_select_arbiter #(
   parameter int BURST_LEN = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic       s1,
   output logic       s0,
   output logic [3:0] gnt,
   output logic       busy,
   output logic [3:0] burst_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] LP_MAX = 4'(BURST_LEN);

   state_t     r_state, w_stateNext;
   logic [3:0] r_gnt,   w_gntNext;
   logic [1:0] r_sel,   w_selNext;
   logic       r_busy,  w_busyNext;
   logic [3:0] r_cnt,   w_cntNext;
   logic [1:0] r_last,  w_lastNext;

   logic       w_release;
   logic [3:0] w_masked;
   logic [1:0] w_winIdle;
   logic [1:0] w_winMasked;

   // First set bit of mask scanning upward from p+1, wrapping 3 -> 0, with p last.
   function automatic logic [1:0] arb(input logic [3:0] mask, input logic [1:0] p);
      logic [1:0] idx;
      logic       found;
      arb   = p;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = p + 2'(i);
         if (!found && mask[idx]) begin
            arb   = idx;
            found = 1'b1;
         end
      end
   endfunction

   assign w_winIdle   = arb(req, r_last);
   assign w_masked    = req & ~(4'b0001 << r_last);
   assign w_winMasked = arb(w_masked, r_last);
   assign w_release   = !req[r_last] || (r_cnt == LP_MAX);

   // Next-state and next-output logic. r_last doubles as the current winner while granting.
   always_comb begin
      w_stateNext = r_state;
      w_gntNext   = r_gnt;
      w_selNext   = r_sel;
      w_busyNext  = r_busy;
      w_cntNext   = r_cnt;
      w_lastNext  = r_last;
      case (r_state)
         IDLE: begin
            if (req != 4'b0000) begin
               w_stateNext = GRANT;
               w_gntNext   = 4'b0001 << w_winIdle;
               w_selNext   = w_winIdle;
               w_busyNext  = 1'b1;
               w_cntNext   = 4'd1;
               w_lastNext  = w_winIdle;
            end
         end
         GRANT: begin
            if (!w_release) begin
               w_cntNext = r_cnt + 4'd1;
            end else if (w_masked != 4'b0000) begin
               w_gntNext  = 4'b0001 << w_winMasked;
               w_selNext  = w_winMasked;
               w_cntNext  = 4'd1;
               w_lastNext = w_winMasked;
            end else if (req[r_last]) begin
               w_cntNext = 4'd1;
            end else begin
               w_stateNext = IDLE;
               w_gntNext   = 4'b0000;
               w_busyNext  = 1'b0;
               w_cntNext   = 4'd0;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // State and output registers. The pointer resets to 3 so that source 0 wins the first arbitration.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_gnt   <= 4'b0000;
         r_sel   <= 2'b00;
         r_busy  <= 1'b0;
         r_cnt   <= 4'd0;
         r_last  <= 2'd3;
      end else begin
         r_state <= w_stateNext;
         r_gnt   <= w_gntNext;
         r_sel   <= w_selNext;
         r_busy  <= w_busyNext;
         r_cnt   <= w_cntNext;
         r_last  <= w_lastNext;
      end
   end

   assign s1        = r_sel[1];
   assign s0        = r_sel[0];
   assign gnt       = r_gnt;
   assign busy      = r_busy;
   assign burst_cnt = r_cnt;

endmodule
